// File: rtl/demux_1to2.sv
// demux_1to2: steers scalar input i onto one of 2**SEL_W output bits chosen by
// the binary index sel_n; every other output bit is 0. With OUT_REG=1 the
// decoded vector passes through one register stage clocked by clk.
module demux_1to2 #(
    parameter int SEL_W   = 1,
    parameter bit OUT_REG = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i,
    input  logic [SEL_W-1:0]      sel_n,
    output logic [2**SEL_W-1:0]   y_out
);

    localparam int N = 2**SEL_W;

    // Decoded value before the optional register stage.
    logic [N-1:0] y_next;

    // One comparator per output bit; sel_n is a plain binary index.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dec
            assign y_next[gi] = (sel_n == SEL_W'(gi)) ? i : 1'b0;
        end
    endgenerate

    generate
        if (OUT_REG) begin : g_reg
            logic [N-1:0] y_reg;

            // Register the decode; reset wins over incoming data.
            always_ff @(posedge clk) begin
                if (rst) begin
                    y_reg <= '0;
                end else begin
                    y_reg <= y_next;
                end
            end

            assign y_out = y_reg;
        end else begin : g_comb
            // clk and rst have no role in the combinational build.
            logic unused_ctl;
            assign unused_ctl = clk ^ rst;

            assign y_out = y_next;
        end
    endgenerate

endmodule

// File: tb/tb_demux_1to2.sv
// Testbench for demux_1to2: combinational 1:2 build, registered 1:2 build and
// combinational 1:4 build, each checked against bench-side expectations.
module tb_demux_1to2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Combinational SEL_W=1 instance
    logic       i0 = 1'b0;
    logic       sel0 = 1'b0;
    logic [1:0] y0;
    // Registered SEL_W=1 instance
    logic       rst1 = 1'b1;
    logic       i1 = 1'b0;
    logic       sel1 = 1'b0;
    logic [1:0] y1;
    // Combinational SEL_W=2 instance
    logic       i2 = 1'b0;
    logic [1:0] sel2 = 2'd0;
    logic [3:0] y2;

    demux_1to2 #(.SEL_W(1), .OUT_REG(1'b0)) dut_comb (
        .clk(clk), .rst(rst1), .i(i0), .sel_n(sel0), .y_out(y0)
    );
    demux_1to2 #(.SEL_W(1), .OUT_REG(1'b1)) dut_reg (
        .clk(clk), .rst(rst1), .i(i1), .sel_n(sel1), .y_out(y1)
    );
    demux_1to2 #(.SEL_W(2), .OUT_REG(1'b0)) dut_w2 (
        .clk(clk), .rst(rst1), .i(i2), .sel_n(sel2), .y_out(y2)
    );

    typedef struct {
        logic [1:0] sel;
        logic       i;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs1[4];
    vec_t vecs2[8];
    logic [1:0] pattern[4];
    logic [1:0] sb_q[$];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    // One registered-mode cycle: compare the output produced from last
    // cycle's inputs, then drive new inputs and queue their expected result.
    task automatic reg_cycle(input logic r, input logic iv, input logic sv);
        logic [1:0] exp;
        @(negedge clk);
        if (sb_q.size() != 0) begin
            exp = sb_q.pop_front();
            check("reg_track", {2'b00, y1}, {2'b00, exp});
        end
        rst1 = r;
        i1   = iv;
        sel1 = sv;
        if (r) exp = 2'b00;
        else   exp = sv ? {iv, 1'b0} : {1'b0, iv};
        sb_q.push_back(exp);
    endtask

    initial begin
        vecs1[0] = '{2'd0, 1'b0, 4'b0000};
        vecs1[1] = '{2'd0, 1'b1, 4'b0001};
        vecs1[2] = '{2'd1, 1'b0, 4'b0000};
        vecs1[3] = '{2'd1, 1'b1, 4'b0010};
        for (int k = 0; k < 4; k++) begin
            vecs2[k]     = '{2'(k), 1'b1, 4'(1 << k)};
            vecs2[k + 4] = '{2'(k), 1'b0, 4'b0000};
        end
        pattern[0] = 2'b00; pattern[1] = 2'b01; pattern[2] = 2'b00; pattern[3] = 2'b10;

        // Exhaustive 1:2 truth table, combinational
        for (int k = 0; k < 4; k++) begin
            sel0 = vecs1[k].sel[0];
            i0   = vecs1[k].i;
            #1;
            check("comb_table", {2'b00, y0}, vecs1[k].exp);
            $display("comb sel=%b i=%b y=%b", sel0, i0, y0);
            #4;
        end

        // i toggles every 10 ns, sel every 20 ns, 500 ns total
        for (int k = 0; k < 50; k++) begin
            i0   = k[0];
            sel0 = k[1];
            #5;
            check("comb_toggle", {2'b00, y0}, {2'b00, pattern[k % 4]});
            check("comb_onehot0", {3'b000, $onehot0(y0)}, 4'b0001);
            #5;
        end

        // 1:4 walk with i=1 then i=0
        for (int k = 0; k < 8; k++) begin
            sel2 = vecs2[k].sel;
            i2   = vecs2[k].i;
            #1;
            check("w2_table", y2, vecs2[k].exp);
            $display("w2 sel=%0d i=%b y=%b", sel2, i2, y2);
            #4;
        end

        // Registered: reset held for two edges with i=1, sel=1
        @(negedge clk);
        rst1 = 1'b1; i1 = 1'b1; sel1 = 1'b1;
        @(negedge clk);
        check("reg_rst_edge1", {2'b00, y1}, 4'b0000);
        @(negedge clk);
        check("reg_rst_edge2", {2'b00, y1}, 4'b0000);
        rst1 = 1'b0;
        @(posedge clk);
        #1;
        check("reg_first_load", {2'b00, y1}, 4'b0010);
        $display("reg release y=%b", y1);

        // Registered: random run with a mid-run reset pulse
        for (int c = 0; c < 1000; c++) begin
            reg_cycle((c == 500), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        if (sb_q.size() != 0) begin
            check("reg_track", {2'b00, y1}, {2'b00, sb_q.pop_front()});
        end

        // Registered: mid-stream reset by hand, data i=1 sel=0 throughout
        @(negedge clk);
        rst1 = 1'b0; i1 = 1'b1; sel1 = 1'b0;
        @(negedge clk);
        check("reg_pre_pulse", {2'b00, y1}, 4'b0001);
        rst1 = 1'b1;
        @(negedge clk);
        check("reg_pulse_clear", {2'b00, y1}, 4'b0000);
        rst1 = 1'b0;
        @(negedge clk);
        check("reg_resume", {2'b00, y1}, 4'b0001);
        $display("reg pulse sequence y=%b", y1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
